// File: rtl/fetch_controller_if.sv
// Fetch-controller signal bundle: pipeline/hazard inputs and PC control outputs.
// The master side is the fetch pipeline (or bench); the slave side is fetch_controller.
interface fetch_controller_if;
    logic [15:0] Instr;
    logic        Instr_Valid;
    logic [7:0]  Instr_Addr;
    logic        Flag_Z;
    logic        Stall_Req;
    logic        Resume;
    logic        Enable_PC;
    logic        Update_PC;
    logic [7:0]  New_Address;
    logic        Flush;
    logic        Halted;
    logic [7:0]  Branch_Count;
    logic [2:0]  Dbg_State;

    // Handshake: an instruction is consumed in a cycle only when Instr_Valid=1 and
    // Stall_Req=0 in RUN; stalled instructions must be re-presented by the master.
    modport master (
        output Instr, Instr_Valid, Instr_Addr, Flag_Z, Stall_Req, Resume,
        input  Enable_PC, Update_PC, New_Address, Flush, Halted, Branch_Count, Dbg_State
    );

    modport slave (
        input  Instr, Instr_Valid, Instr_Addr, Flag_Z, Stall_Req, Resume,
        output Enable_PC, Update_PC, New_Address, Flush, Halted, Branch_Count, Dbg_State
    );
endinterface

// File: rtl/fetch_controller.sv
// PC sequencing FSM: jumps, conditional/relative branches, halt/resume, pipeline flush.
// Optional taken-branch counter enabled by macro FETCH_BRANCH_COUNT_EN.
module fetch_controller (
    input  logic               clk,
    input  logic               Reset,
    fetch_controller_if.slave  fc
);

    typedef enum logic [2:0] {
        START  = 3'd0,
        RUN    = 3'd1,
        FLUSH1 = 3'd2,
        FLUSH2 = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  opcode;
    logic [7:0]  rel_target;
    logic [7:0]  target;
    logic        taken;
    logic        is_halt;
    logic        en_pc, upd_pc, flush, halted;
    logic [7:0]  new_addr;
    logic        unused_instr_bits;

    assign opcode            = fc.Instr[15:12];
    assign unused_instr_bits = ^fc.Instr[11:8];
    // An 8-bit add of the raw offset equals sign-extended addition modulo 256.
    assign rel_target        = fc.Instr_Addr + fc.Instr[7:0];
    assign is_halt           = (opcode == 4'hF);

    always_comb begin
        taken  = 1'b0;
        target = 8'h00;
        case (opcode)
            4'hA: begin
                taken  = 1'b1;
                target = fc.Instr[7:0];
            end
            4'hB: begin
                taken  = fc.Flag_Z;
                target = fc.Instr[7:0];
            end
            4'hC: begin
                taken  = 1'b1;
                target = rel_target;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        en_pc    = 1'b0;
        upd_pc   = 1'b0;
        new_addr = 8'h00;
        flush    = 1'b0;
        halted   = 1'b0;
        case (state_q)
            START: state_d = RUN;
            RUN: begin
                if (fc.Stall_Req) begin
                    state_d = RUN;
                end else if (fc.Instr_Valid && taken) begin
                    upd_pc   = 1'b1;
                    new_addr = target;
                    state_d  = FLUSH1;
                end else if (fc.Instr_Valid && is_halt) begin
                    flush   = 1'b1;
                    state_d = HALT;
                end else begin
                    en_pc = 1'b1;
                end
            end
            FLUSH1: begin
                flush   = 1'b1;
                en_pc   = 1'b1;
                state_d = FLUSH2;
            end
            FLUSH2: begin
                flush   = 1'b1;
                en_pc   = 1'b1;
                state_d = RUN;
            end
            HALT: begin
                halted = 1'b1;
                if (fc.Resume) state_d = FLUSH1;
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state_q <= START;
        else        state_q <= state_d;
    end

    assign fc.Enable_PC   = en_pc;
    assign fc.Update_PC   = upd_pc;
    assign fc.New_Address = new_addr;
    assign fc.Flush       = flush;
    assign fc.Halted      = halted;
    assign fc.Dbg_State   = state_q;

`ifdef FETCH_BRANCH_COUNT_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (upd_pc && (count_q != 8'hFF)) count_d = count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) count_q <= 8'h00;
        else        count_q <= count_d;
    end

    assign fc.Branch_Count = count_q;
`else
    assign fc.Branch_Count = 8'h00;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed, table-driven bench for fetch_controller plus reset/saturation sequences.
module tb_fetch_controller;

    typedef struct {
        logic        valid;
        logic [15:0] instr;
        logic [7:0]  addr;
        logic        z;
        logic        stall;
        logic        resume;
        logic        en;
        logic        upd;
        logic [7:0]  na;
        logic        flush;
        logic        halt;
    } vec_t;

`ifdef FETCH_BRANCH_COUNT_EN
    localparam bit BC_EN = 1'b1;
`else
    localparam bit BC_EN = 1'b0;
`endif

    logic clk;
    logic Reset;
    int   checks;
    int   failures;
    int   bc_model;
    vec_t tbl[$];

    fetch_controller_if fc ();

    fetch_controller dut (
        .clk   (clk),
        .Reset (Reset),
        .fc    (fc)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(logic valid, logic [15:0] instr, logic [7:0] addr,
                                logic z, logic stall, logic resume,
                                logic en, logic upd, logic [7:0] na,
                                logic flush, logic halt);
        vec_t v;
        v.valid = valid; v.instr = instr; v.addr = addr;
        v.z = z; v.stall = stall; v.resume = resume;
        v.en = en; v.upd = upd; v.na = na; v.flush = flush; v.halt = halt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, logic en, logic upd, logic [7:0] na,
                              logic flush, logic halt);
        logic [7:0] exp_bc;
        exp_bc = BC_EN ? 8'(bc_model) : 8'h00;
        chk({tag, " Enable_PC"},    32'(fc.Enable_PC),    32'(en));
        chk({tag, " Update_PC"},    32'(fc.Update_PC),    32'(upd));
        chk({tag, " New_Address"},  32'(fc.New_Address),  32'(na));
        chk({tag, " Flush"},        32'(fc.Flush),        32'(flush));
        chk({tag, " Halted"},       32'(fc.Halted),       32'(halt));
        chk({tag, " Branch_Count"}, 32'(fc.Branch_Count), 32'(exp_bc));
    endtask

    // Drivers
    task automatic drive(vec_t v);
        fc.Instr_Valid = v.valid;
        fc.Instr       = v.instr;
        fc.Instr_Addr  = v.addr;
        fc.Flag_Z      = v.z;
        fc.Stall_Req   = v.stall;
        fc.Resume      = v.resume;
    endtask

    task automatic run_vec(vec_t v, string tag);
        drive(v);
        @(negedge clk);
        check_outs(tag, v.en, v.upd, v.na, v.flush, v.halt);
        if (v.upd && bc_model < 255) bc_model++;
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset_check(string tag);
        Reset = 1'b0;
        bc_model = 0;
        #1;
        check_outs(tag, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk({tag, " state"}, 32'(fc.Dbg_State), 32'd0);
        @(posedge clk);
        #1;
        check_outs({tag, " held"}, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        Reset = 1'b1;
    endtask

    initial begin
        vec_t idle, jmp, f_halt, fl;
        checks   = 0;
        failures = 0;
        bc_model = 0;
        Reset    = 1'b0;
        idle   = mk(0, 16'h0000, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        jmp    = mk(1, 16'hA042, 8'h10, 0, 0, 0, 0, 1, 8'h42, 0, 0);
        f_halt = mk(1, 16'hF000, 8'h20, 0, 0, 0, 0, 0, 8'h00, 1, 0);
        fl     = mk(1, 16'hA042, 8'h00, 1, 1, 1, 1, 0, 8'h00, 1, 0);
        drive(idle);

        // Per-cycle vectors starting in the START cycle after reset release.
        tbl.push_back(mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0)); // START
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(jmp);
        tbl.push_back(fl);
        tbl.push_back(fl);
        tbl.push_back(idle);
        tbl.push_back(mk(1, 16'hB010, 8'h30, 0, 0, 0, 1, 0, 8'h00, 0, 0)); // JZ not taken
        tbl.push_back(mk(1, 16'hB010, 8'h31, 1, 0, 0, 0, 1, 8'h10, 0, 0)); // JZ taken
        tbl.push_back(fl);
        tbl.push_back(fl);
        tbl.push_back(mk(1, 16'hC005, 8'hFE, 0, 0, 0, 0, 1, 8'h03, 0, 0)); // BR wrap up
        tbl.push_back(fl);
        tbl.push_back(fl);
        tbl.push_back(mk(1, 16'hC0FC, 8'h02, 0, 0, 0, 0, 1, 8'hFE, 0, 0)); // BR backward
        tbl.push_back(fl);
        tbl.push_back(fl);
        tbl.push_back(mk(1, 16'hA042, 8'h40, 0, 1, 0, 0, 0, 8'h00, 0, 0)); // stalled JMP
        tbl.push_back(jmp);
        tbl.push_back(fl);
        tbl.push_back(fl);
        tbl.push_back(mk(0, 16'hA042, 8'h00, 1, 0, 1, 1, 0, 8'h00, 0, 0)); // invalid JMP
        tbl.push_back(f_halt);
        tbl.push_back(mk(1, 16'hA042, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 1)); // HALT
        tbl.push_back(mk(0, 16'h0000, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 16'h0000, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1)); // Resume
        tbl.push_back(fl);
        tbl.push_back(fl);
        tbl.push_back(idle);
        tbl.push_back(mk(1, 16'h1234, 8'h50, 1, 0, 0, 1, 0, 8'h00, 0, 0)); // other opcode

        hold_reset_check("reset");
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec[%0d]", i));

        // Reset in FLUSH1 abandons the flush sequence.
        run_vec(jmp, "pre_rst_flush jmp");
        hold_reset_check("rst_in_flush");
        run_vec(tbl[0], "rst_in_flush start");
        run_vec(idle, "rst_in_flush run");

        // Reset in HALT.
        run_vec(f_halt, "pre_rst_halt");
        run_vec(mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1), "in_halt");
        hold_reset_check("rst_in_halt");
        run_vec(tbl[0], "rst_in_halt start");
        run_vec(idle, "rst_in_halt run");

        // 300 taken branches saturate the counter when it is present.
        for (int i = 0; i < 300; i++) begin
            run_vec(jmp, "sat jmp");
            run_vec(fl, "sat flush1");
            run_vec(fl, "sat flush2");
        end
        chk("sat final Branch_Count", 32'(fc.Branch_Count), BC_EN ? 32'hFF : 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Instr, input, 16 bits: fetched instruction; [15:12] opcode, [7:0] target/offset.
REQ-004 SHALL have port Instr_Valid, input, 1 bit: Instr and Instr_Addr are meaningful this cycle.
REQ-005 SHALL have port Instr_Addr, input, 8 bits: address of Instr (the program counter's two-cycle-delayed copy).
REQ-006 SHALL have port Flag_Z, input, 1 bit: ALU zero flag, sampled in the same cycle as Instr.
REQ-007 SHALL have port Stall_Req, input, 1 bit: hazard unit requests PC hold.
REQ-008 SHALL have port Resume, input, 1 bit: leave HALT.
REQ-009 SHALL have port Enable_PC, output, 1 bit: PC increments by 1 at the next edge.
REQ-010 SHALL have port Update_PC, output, 1 bit: PC loads New_Address at the next edge.
REQ-011 SHALL have port New_Address, output, 8 bits: branch/jump target.
REQ-012 SHALL have port Flush, output, 1 bit: squash the in-flight instruction this cycle.
REQ-013 SHALL have port Halted, output, 1 bit: controller is in HALT.
REQ-014 SHALL have port Branch_Count, output, 8 bits: taken-branch counter (see Configuration).

Function
REQ-015 SHALL implement states START, RUN, FLUSH1, FLUSH2, HALT; outputs are combinational from state and inputs.
REQ-016 SHALL, in START, drive all outputs 0 and go to RUN on the next edge.
REQ-017 SHALL decode opcodes: 4'hA JMP (target = Instr[7:0]); 4'hB JZ (taken iff Flag_Z=1, target = Instr[7:0]); 4'hC BR (target = Instr_Addr + sign-extended Instr[7:0], modulo 256); 4'hF HALT; all others sequential.
REQ-018 SHALL, in RUN with Stall_Req=1, drive Enable_PC=0 and Update_PC=0, ignore Instr, and stay in RUN; stall wins over a simultaneous branch, which must be re-presented.
REQ-019 SHALL, in RUN with Stall_Req=0 and no taken branch or HALT, drive Enable_PC=1 and Update_PC=0.
REQ-020 SHALL, in RUN with Stall_Req=0, Instr_Valid=1 and a taken branch, drive Update_PC=1, Enable_PC=0, New_Address=target for exactly one cycle, then go to FLUSH1.
REQ-021 SHALL, in FLUSH1 and FLUSH2, drive Flush=1, Enable_PC=1, Update_PC=0, ignore Instr_Valid, Stall_Req and Flag_Z, and advance FLUSH1->FLUSH2->RUN.
REQ-022 SHALL, in RUN with Stall_Req=0, Instr_Valid=1 and opcode HALT, drive Enable_PC=0, go to HALT, and drive Flush=1 for the same cycle.
REQ-023 SHALL, in HALT, drive Halted=1, Enable_PC=0 and Update_PC=0; Resume=1 moves to FLUSH1 so the stale pipeline contents are squashed.
REQ-024 SHALL drive New_Address=0 whenever Update_PC=0.
REQ-025 SHALL treat a not-taken JZ as sequential, with no Flush.
REQ-026 SHALL wrap BR targets at 8 bits, e.g. 0xFE + 0x05 = 0x03 and 0x02 + 0xFC = 0xFE.

Reset
REQ-027 SHALL, while Reset=0, immediately force state START and Branch_Count=0, so that Enable_PC=0, Update_PC=0, New_Address=0, Flush=0, Halted=0.
REQ-028 SHALL, on Reset asserted mid-FLUSH or in HALT, abandon that state with no further Flush pulses.
REQ-029 SHALL leave START on the first rising edge after Reset deasserts.

Configuration
REQ-030 SHALL, with macro FETCH_BRANCH_COUNT_EN defined, increment Branch_Count on each cycle with Update_PC=1, saturating at 0xFF.
REQ-031 SHALL, without FETCH_BRANCH_COUNT_EN, keep the Branch_Count port present and tied to 0.

Verification
REQ-032 SHALL check: release Reset, Instr_Valid=0 -> one cycle with Enable_PC=0, then Enable_PC=1 every cycle.
REQ-033 SHALL check: RUN, Instr=16'hA042 valid -> Update_PC=1 and New_Address=0x42 for one cycle, then Flush=1 for 2 cycles, then RUN.
REQ-034 SHALL check: Instr=16'hB010 with Flag_Z=0 -> no Update_PC and no Flush; with Flag_Z=1 -> New_Address=0x10.
REQ-035 SHALL check: Instr_Addr=0xFE, Instr=16'hC005 -> New_Address=0x03; Instr_Addr=0x02, Instr=16'hC0FC -> New_Address=0xFE.
REQ-036 SHALL check: Stall_Req=1 together with Instr=16'hA042 -> Enable_PC=0 and Update_PC=0; after Stall_Req drops, the branch is taken.
REQ-037 SHALL check: Instr=16'hF000 -> Halted=1 and Enable_PC=0 until Resume -> 2 Flush cycles, then RUN; with FETCH_BRANCH_COUNT_EN, 300 taken branches -> Branch_Count=0xFF.
